// File: rtl/park_ctrl_multi.sv
// Multi-floor parking controller: per-floor free-spot counters, lowest-free-floor
// routing, a timed entry gate, and pulses for refused entries and illegal exits.
module park_ctrl_multi #(
  parameter int NUM_FLOORS      = 4,
  parameter int SPOTS_PER_FLOOR = 9,
  parameter int GATE_CYCLES     = 3,
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1,
  localparam int CW = $clog2(SPOTS_PER_FLOOR + 1),
  localparam int TW = $clog2(NUM_FLOORS * SPOTS_PER_FLOOR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_in,
  input  logic          car_out,
  input  logic [FW-1:0] out_floor,
  output logic [FW-1:0] current_floor,
  output logic [CW-1:0] floor_free,
  output logic [TW-1:0] free_total,
  output logic          parking_full,
  output logic          parking_empty,
  output logic          gate_open,
  output logic          in_reject,
  output logic          out_error
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CW-1:0]   count_q [NUM_FLOORS];
  logic [CW-1:0]   count_d [NUM_FLOORS];
  logic [TW-1:0]   total_q, total_d;
  logic            in_q, out_q;
  logic            in_reject_q, in_reject_d;
  logic            out_error_q, out_error_d;

  logic            entry_ev, exit_ev;
  logic            full;
  logic            entry_ok, exit_ok;
  logic [FW-1:0]   cur_floor;
  logic [FW-1:0]   out_idx;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    entry_ev = car_in & ~in_q;
    exit_ev  = car_out & ~out_q;
    full     = (total_q == '0);

    // Lowest floor with a free spot; falls back to floor 0 when all are full.
    cur_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (count_q[i] != '0) cur_floor = FW'(i);
    end

    // Out-of-range floors never index the counter array.
    out_idx = '0;
    exit_ok = 1'b0;
    if (32'(out_floor) < 32'(NUM_FLOORS)) begin
      out_idx = out_floor;
      exit_ok = exit_ev && (count_q[out_floor] < CW'(SPOTS_PER_FLOOR));
    end

    entry_ok    = (state_q == ST_IDLE) && entry_ev && !full;
    in_reject_d = (state_q == ST_IDLE) && entry_ev && full;
    out_error_d = exit_ev && !exit_ok;

    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (entry_ok) begin
          state_d    = ST_OPEN;
          gate_cnt_d = GW'(GATE_CYCLES - 1);
        end
      end
      ST_OPEN: begin
        if (gate_cnt_q == '0) state_d = ST_IDLE;
        else                  gate_cnt_d = gate_cnt_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Entry and exit are both judged on the pre-cycle counts; on the same
    // floor they cancel.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      count_d[i] = count_q[i];
      if (entry_ok && (cur_floor == FW'(i))) count_d[i] = count_d[i] - CW'(1);
      if (exit_ok && (out_idx == FW'(i)))    count_d[i] = count_d[i] + CW'(1);
    end
    total_d = total_q - TW'(entry_ok) + TW'(exit_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. The counter array
  // is reset too, since a reset must restore a fully free garage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gate_cnt_q  <= '0;
      total_q     <= TW'(NUM_FLOORS * SPOTS_PER_FLOOR);
      in_q        <= 1'b0;
      out_q       <= 1'b0;
      in_reject_q <= 1'b0;
      out_error_q <= 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) count_q[i] <= CW'(SPOTS_PER_FLOOR);
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      total_q     <= total_d;
      in_q        <= car_in;
      out_q       <= car_out;
      in_reject_q <= in_reject_d;
      out_error_q <= out_error_d;
      for (int i = 0; i < NUM_FLOORS; i++) count_q[i] <= count_d[i];
    end
  end

  assign current_floor = cur_floor;
  assign floor_free    = count_q[cur_floor];
  assign free_total    = total_q;
  assign parking_full  = full;
  assign parking_empty = (total_q == TW'(NUM_FLOORS * SPOTS_PER_FLOOR));
  assign gate_open     = (state_q == ST_OPEN);
  assign in_reject     = in_reject_q;
  assign out_error     = out_error_q;

endmodule
